// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, drives the instruction SRAM and queues {pc, instr} in a small FIFO for decode.
// Define FETCH_PERF_CNT_EN to add stall_cnt, a saturating count of cycles stalled by a full FIFO.
module fetch_unit #(
  parameter int ADDR = 8,
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter logic [ADDR-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fetch_en,
  input  logic             redirect,
  input  logic [ADDR-1:0]  redirect_pc,
  output logic             imem_cs,
  output logic [ADDR-1:0]  imem_addr,
  input  logic [WIDTH-1:0] imem_instr,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [WIDTH-1:0] instr_out,
  output logic [ADDR-1:0]  instr_pc
`ifdef FETCH_PERF_CNT_EN
  ,output logic [15:0]     stall_cnt
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  logic [ADDR-1:0] pc;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [WIDTH-1:0] fifo_instr [DEPTH];
  logic [ADDR-1:0] fifo_pc [DEPTH];
  logic pop, push;
  assign instr_valid = count != '0;
  assign pop = instr_valid & instr_ready;
  // a pop frees the head slot in the same cycle, so a full FIFO still streams
  assign push = fetch_en & ~redirect & ((count < FULL) | pop);
  assign imem_cs = push & rst_n;
  assign imem_addr = pc;
  assign instr_out = instr_valid ? fifo_instr[rd_ptr] : '0;
  assign instr_pc = instr_valid ? fifo_pc[rd_ptr] : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else if (redirect) begin
      pc <= redirect_pc;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      pc <= push ? pc + ADDR'(1) : pc;
      wr_ptr <= wr_ptr + PW'(push);
      rd_ptr <= rd_ptr + PW'(pop);
      count <= count + CW'(push) - CW'(pop);
    end
  always_ff @(posedge clk)
    if (push) begin
      fifo_instr[wr_ptr] <= imem_instr;
      fifo_pc[wr_ptr] <= pc;
    end
`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) stall_cnt <= '0;
    else if (fetch_en & ~redirect & ~push & ~&stall_cnt) stall_cnt <= stall_cnt + 16'd1;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit against hand-computed values; SRAM word = 0xA000_0000 + address.
module tb_fetch_unit;
  logic clk = 0, rst_n = 0, fetch_en = 0, redirect = 0, instr_ready = 0;
  logic [7:0] redirect_pc = '0, imem_addr, instr_pc;
  logic imem_cs, instr_valid;
  logic [31:0] imem_instr, instr_out;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] stall_cnt;
`endif
  int n_chk = 0, n_err = 0;
  always #5 clk = ~clk;
  assign imem_instr = 32'hA000_0000 + {24'd0, imem_addr};
  fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_cs(imem_cs), .imem_addr(imem_addr),
    .imem_instr(imem_instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_out(instr_out), .instr_pc(instr_pc)
`ifdef FETCH_PERF_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  initial begin
    logic [7:0] wrap_seq [4];
    wrap_seq = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    fetch_en = 1;
    @(negedge clk);
    @(negedge clk);
    check("rst_cs", {31'd0, imem_cs}, 0);
    check("rst_addr", {24'd0, imem_addr}, 0);
    check("rst_valid", {31'd0, instr_valid}, 0);
    check("rst_out", instr_out, 0);
    check("rst_pc", {24'd0, instr_pc}, 0);
    rst_n = 1;
    #1 check("first_cs", {31'd0, imem_cs}, 1);
    @(negedge clk);
    check("first_valid", {31'd0, instr_valid}, 1);
    check("first_pc", {24'd0, instr_pc}, 0);
    check("first_out", instr_out, 32'hA000_0000);
    repeat (4) @(negedge clk);
    check("full_cs", {31'd0, imem_cs}, 0);
    check("full_addr", {24'd0, imem_addr}, 2);
    check("full_head", {24'd0, instr_pc}, 0);
    instr_ready = 1;
    #1 check("full_push_pop_cs", {31'd0, imem_cs}, 1);
    for (int i = 0; i < 10; i++) begin
      check("stream_valid", {31'd0, instr_valid}, 1);
      check("stream_pc", {24'd0, instr_pc}, i);
      check("stream_out", instr_out, 32'hA000_0000 + i);
      @(negedge clk);
    end
    check("pre_redir_pc", {24'd0, instr_pc}, 10);
    check("pre_redir_addr", {24'd0, imem_addr}, 12);
    redirect = 1;
    redirect_pc = 8'h40;
    #1 check("redir_cs", {31'd0, imem_cs}, 0);
    @(negedge clk);
    redirect = 0;
    #1 check("redir_valid", {31'd0, instr_valid}, 0);
    check("redir_addr", {24'd0, imem_addr}, 8'h40);
    @(negedge clk);
    check("redir_first_valid", {31'd0, instr_valid}, 1);
    check("redir_first_pc", {24'd0, instr_pc}, 8'h40);
    check("redir_first_out", instr_out, 32'hA000_0040);
    @(negedge clk);
    check("redir_second_pc", {24'd0, instr_pc}, 8'h41);
    redirect = 1;
    redirect_pc = 8'hFE;
    @(negedge clk);
    redirect = 0;
    #1 check("wrap_flush_valid", {31'd0, instr_valid}, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("wrap_pc", {24'd0, instr_pc}, {24'd0, wrap_seq[k]});
      check("wrap_out", instr_out, 32'hA000_0000 + {24'd0, wrap_seq[k]});
    end
    @(negedge clk);
    fetch_en = 0;
    #1 check("noen_cs", {31'd0, imem_cs}, 0);
    check("noen_addr", {24'd0, imem_addr}, 3);
    check("noen_head", {24'd0, instr_pc}, 2);
    @(negedge clk);
    check("drain_valid", {31'd0, instr_valid}, 0);
    check("drain_out", instr_out, 0);
    check("drain_addr", {24'd0, imem_addr}, 3);
    fetch_en = 1;
    instr_ready = 0;
    repeat (3) @(negedge clk);
    check("refill_valid", {31'd0, instr_valid}, 1);
    #2 rst_n = 0;
    #1 check("async_valid", {31'd0, instr_valid}, 0);
    check("async_cs", {31'd0, imem_cs}, 0);
    check("async_addr", {24'd0, imem_addr}, 0);
    check("async_out", instr_out, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check("rerun_pc", {24'd0, instr_pc}, 0);
    check("rerun_out", instr_out, 32'hA000_0000);
`ifdef FETCH_PERF_CNT_EN
    repeat (8) @(negedge clk);
    check("stall_cnt", {16'd0, stall_cnt}, 7);
    redirect = 1;
    redirect_pc = 8'h10;
    @(negedge clk);
    redirect = 0;
    #1 check("stall_cnt_redir", {16'd0, stall_cnt}, 7);
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage placed directly upstream of the instruction SRAM and downstream of nothing but the branch/redirect logic. It owns the program counter and drives the SRAM's chip-select and address. It captures the combinational instruction word the SRAM returns for that address and queues it, with its PC, in a small FIFO. Decode drains the FIFO through a valid/ready handshake.

## Interface
- `ADDR`, 8, PC / SRAM address width
- `WIDTH`, 32, instruction width
- `DEPTH`, 2, fetch FIFO entries; power of two, ≥2
- `RESET_PC`, 0, PC value after reset

- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `fetch_en`  in  1  allow fetching
- `redirect`  in  1  branch/jump taken; flush and reload PC
- `redirect_pc`  in  ADDR  new PC when `redirect`=1
- `imem_cs`  out  1  SRAM chip select, combinational
- `imem_addr`  out  ADDR  SRAM address; equals the current PC register
- `imem_instr`  in  WIDTH  SRAM combinational instruction word for `imem_addr`
- `instr_valid`  out  1  FIFO non-empty
- `instr_ready`  in  1  decode accepts head entry
- `instr_out`  out  WIDTH  head instruction; 0 when `instr_valid`=0
- `instr_pc`  out  ADDR  PC of head instruction; 0 when `instr_valid`=0

## Operation
- State: `pc` (ADDR bits), FIFO storage, read and write pointers, and `count` (0..DEPTH).
- `pop` = `instr_valid` & `instr_ready`.
- `push` = `fetch_en` & ~`redirect` & (`count`<DEPTH | `pop`).
- `imem_cs` = `push`; forced to 0 while `rst_n`=0.
- On `push`:
  - Write {`pc`, `imem_instr`} at the write pointer.
  - `pc` ← `pc`+1, modulo 2^ADDR; 0xFF wraps to 0x00 at ADDR=8.
- On `pop`: advance the read pointer.
- `count` updates by +push −pop. Push and pop in the same cycle leave `count` unchanged, including when full.
- On `redirect`:
  - `count` ← 0 and both pointers ← 0.
  - `pc` ← `redirect_pc`; no push that cycle.
  - A simultaneous pop is discarded as part of the flush; decode must treat the handshake as void.
  - `redirect` takes priority over every other event.
- `fetch_en`=0: no push and `pc` holds. Pops continue.
- Pointers wrap modulo DEPTH.

## Timing
- Reset (async assert, sync release) values:
  - `pc`=RESET_PC, `count`=0
  - `instr_valid`=0, `instr_out`=0, `instr_pc`=0, `imem_cs`=0
  - `imem_addr`=RESET_PC
- Fetch latency: a word captured at edge N is visible on `instr_out` after edge N, so decode can take it in cycle N+1.
- Sustained throughput is 1 instruction/cycle when `instr_ready`=1.
- First valid appears 1 cycle after reset release with `fetch_en`=1.
- After `redirect` at edge N:
  - `instr_valid`=0 and `imem_addr`=`redirect_pc` in cycle N+1.
  - The first post-redirect instruction is valid in cycle N+2.
- When full with `instr_ready`=0: `imem_cs`=0 and `pc` holds until a pop occurs.
- `rst_n` asserted mid-stream: all queued entries are lost immediately and the outputs show reset values asynchronously.

## Configuration
- Macro: `FETCH_PERF_CNT_EN`.
- Defined:
  - Adds output `stall_cnt` [15:0], reset to 0.
  - Increments each cycle with `fetch_en`=1, `redirect`=0 and `push`=0, i.e. stalled by a full FIFO.
  - Saturates at 0xFFFF and is not cleared by `redirect`.
- Undefined: port and counter are absent; behaviour is otherwise identical.

## Test plan
- Reset: hold `rst_n`=0 with `fetch_en`=1 → `imem_cs`=0, `imem_addr`=RESET_PC, `instr_valid`=0, `instr_out`=0. Release → first entry {pc 0x00, mem[0]} valid one cycle later.
- Streaming: mem[i]=0xA000_0000+i, `instr_ready`=1 for 10 cycles → `instr_pc` 0,1,2,… one per cycle, with `instr_out` matching mem.
- Backpressure: `instr_ready`=0 for 5 cycles → `count`=DEPTH=2, `pc`=2, `imem_cs`=0. Raise ready while full → push+pop in the same cycle, `count` stays 2, order preserved.
- Redirect: with 2 queued entries, pulse `redirect`, `redirect_pc`=0x40, `instr_ready`=1 → next cycle `instr_valid`=0 and `imem_addr`=0x40; the cycle after, `instr_pc`=0x40.
- Wrap: `redirect_pc`=0xFE, stream → `instr_pc` sequence 0xFE, 0xFF, 0x00, 0x01.
- With `FETCH_PERF_CNT_EN`: full FIFO, `instr_ready`=0 for 7 stalled cycles → `stall_cnt`=7. A `redirect` leaves it at 7.
